// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer controller and its
// optional mm:ss BCD converter (enabled with TIMER_BCD_EN).
package timer_pkg;

  localparam int CNT_W_DEF     = 12;
  localparam int ALARM_SEC_DEF = 5;
  localparam int BCD_DIGIT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ALARM  = 3'd4
  } timer_state_e;

  typedef enum logic [1:0] {
    CV_IDLE = 2'd0,
    CV_MIN  = 2'd1,
    CV_SEC  = 2'd2
  } conv_phase_e;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [2*BCD_DIGIT_W-1:0] bcd2_inc_sat(input logic [2*BCD_DIGIT_W-1:0] v);
    logic [2*BCD_DIGIT_W-1:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mmss_bcd_conv.sv
// Sequential seconds-to-mm:ss BCD converter: repeated subtract-60 builds the
// minute digits, then subtract-10 splits the seconds. Outputs update on done.
module mmss_bcd_conv
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       bcd_min_o,
  output logic [7:0]       bcd_sec_o
);

  localparam logic [CNT_W-1:0] SIXTY = CNT_W'(60);
  localparam logic [CNT_W-1:0] TEN   = CNT_W'(10);

  conv_phase_e      phase_q;
  logic [CNT_W-1:0] work_q;
  logic [7:0]       min_acc_q;
  logic [3:0]       sec_tens_q;
  logic [7:0]       bcd_min_q;
  logic [7:0]       bcd_sec_q;
  logic             done_q;

  // A new start always restarts the conversion, even mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= CV_IDLE;
      work_q     <= {CNT_W{1'b0}};
      min_acc_q  <= 8'h00;
      sec_tens_q <= 4'd0;
      bcd_min_q  <= 8'h00;
      bcd_sec_q  <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        work_q     <= value_i;
        min_acc_q  <= 8'h00;
        sec_tens_q <= 4'd0;
        phase_q    <= CV_MIN;
      end else begin
        case (phase_q)
          CV_MIN: begin
            if (work_q >= SIXTY) begin
              work_q    <= work_q - SIXTY;
              min_acc_q <= bcd2_inc_sat(min_acc_q);
            end else begin
              phase_q <= CV_SEC;
            end
          end
          CV_SEC: begin
            if (work_q >= TEN) begin
              work_q     <= work_q - TEN;
              sec_tens_q <= sec_tens_q + 4'd1;
            end else begin
              bcd_sec_q <= {sec_tens_q, work_q[3:0]};
              bcd_min_q <= min_acc_q;
              done_q    <= 1'b1;
              phase_q   <= CV_IDLE;
            end
          end
          CV_IDLE: phase_q <= CV_IDLE;
          default: phase_q <= CV_IDLE;
        endcase
      end
    end
  end

  assign busy_o    = (phase_q != CV_IDLE);
  assign done_o    = done_q;
  assign bcd_min_o = bcd_min_q;
  assign bcd_sec_o = bcd_sec_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: load/run/pause/alarm FSM on debounced pulses and
// a 1 Hz tick. Define TIMER_BCD_EN to add the bcd_min/bcd_sec mm:ss outputs.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ALARM_SEC = ALARM_SEC_DEF
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             result_start,
  input  logic             result_stop,
  input  logic             result_load,
  input  logic             result_reset,
  input  logic [CNT_W-1:0] preset_sec,
  output logic [CNT_W-1:0] remaining_sec,
  output logic             running,
  output logic             buzzer_en,
  output logic             expired
`ifdef TIMER_BCD_EN
  ,
  output logic [7:0]       bcd_min,
  output logic [7:0]       bcd_sec
`endif
);

  localparam int               AW         = $clog2(ALARM_SEC + 1);
  localparam logic [AW-1:0]    ALARM_LAST = AW'(ALARM_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  timer_state_e     state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [AW-1:0]    alarm_cnt_q;
  logic             running_q;
  logic             buzzer_q;
  logic             expired_q;

  // Pulse priority: reset > load > stop > start > tick; a tick is dropped
  // whenever any higher-priority pulse is present in the same cycle.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= CNT_ZERO;
      alarm_cnt_q <= {AW{1'b0}};
      running_q   <= 1'b0;
      buzzer_q    <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (result_reset) begin
        state_q     <= ST_IDLE;
        remaining_q <= CNT_ZERO;
        alarm_cnt_q <= {AW{1'b0}};
        running_q   <= 1'b0;
        buzzer_q    <= 1'b0;
      end else if (result_load) begin
        if (preset_sec != CNT_ZERO) begin
          state_q     <= ST_LOADED;
          remaining_q <= preset_sec;
          alarm_cnt_q <= {AW{1'b0}};
          running_q   <= 1'b0;
          buzzer_q    <= 1'b0;
        end else begin
          state_q <= state_q;
        end
      end else if (result_stop) begin
        case (state_q)
          ST_RUN: begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
          ST_ALARM: begin
            state_q     <= ST_IDLE;
            buzzer_q    <= 1'b0;
            alarm_cnt_q <= {AW{1'b0}};
          end
          default: state_q <= state_q;
        endcase
      end else if (result_start) begin
        case (state_q)
          ST_LOADED, ST_PAUSE: begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
          default: state_q <= state_q;
        endcase
      end else if (tick_1hz) begin
        case (state_q)
          ST_RUN: begin
            if (remaining_q == CNT_ONE) begin
              remaining_q <= CNT_ZERO;
              state_q     <= ST_ALARM;
              running_q   <= 1'b0;
              buzzer_q    <= 1'b1;
              expired_q   <= 1'b1;
              alarm_cnt_q <= {AW{1'b0}};
            end else if (remaining_q != CNT_ZERO) begin
              remaining_q <= remaining_q - CNT_ONE;
            end else begin
              remaining_q <= CNT_ZERO;
            end
          end
          ST_ALARM: begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_q     <= ST_IDLE;
              buzzer_q    <= 1'b0;
              alarm_cnt_q <= {AW{1'b0}};
            end else begin
              alarm_cnt_q <= alarm_cnt_q + AW'(1);
            end
          end
          default: state_q <= state_q;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign remaining_sec = remaining_q;
  assign running       = running_q;
  assign buzzer_en     = buzzer_q;
  assign expired       = expired_q;

`ifdef TIMER_BCD_EN
  logic [CNT_W-1:0] prev_rem_q;
  logic             conv_start_s;

  assign conv_start_s = (remaining_q != prev_rem_q);

  // Remembers the last count so any change restarts the conversion.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      prev_rem_q <= CNT_ZERO;
    end else begin
      prev_rem_q <= remaining_q;
    end
  end

  mmss_bcd_conv #(.CNT_W(CNT_W)) u_bcd_conv (
    .clk       (clk_50MHz),
    .rst_n     (reset),
    .start_i   (conv_start_s),
    .value_i   (remaining_q),
    .busy_o    (),
    .done_o    (),
    .bcd_min_o (bcd_min),
    .bcd_sec_o (bcd_sec)
  );
`endif

endmodule
